// File: rtl/axi_dac_jesd204_tx_channel.sv
// Per-channel JESD204 DAC sample source: DMA, pattern, PN7, PN15 (optional), ramp or zero.
// Latency: 1 dac_clk cycle from sampled inputs to registered dac_data / dac_unf / dac_unf_count.
// Backpressure: none; dac_dma_ready is combinational and a missing DMA word is counted as underflow.
//
// Optional feature macro: AXI_DAC_JESD204_PN15_EN builds the PN15 generator; without it
// select 3 outputs zero like select 5.
//
// Ports:
//   dac_clk, dac_rst          clock, asynchronous active-high reset
//   dac_enable, dac_data_sel  channel enable and source select (0 DMA, 1 pattern, 2 PN7,
//                             3 PN15, 4 ramp, others zero)
//   dac_pat_data_1/_2         pattern for even / odd sample slots
//   dac_dma_data/_valid/_ready DMA sample word, sample n at [n*CHANNEL_WIDTH +: CHANNEL_WIDTH]
//   dac_unf_clr               clears the underflow counter (wins over a coincident underflow)
//   dac_data                  registered sample word to the framer
//   dac_unf, dac_unf_count    underflow pulse and saturating 16-bit underflow counter
module axi_dac_jesd204_tx_channel #(
    parameter int CHANNEL_WIDTH   = 16,
    parameter int DATA_PATH_WIDTH = 2
) (
    input  logic                                       dac_clk,
    input  logic                                       dac_rst,
    input  logic                                       dac_enable,
    input  logic [3:0]                                 dac_data_sel,
    input  logic [CHANNEL_WIDTH-1:0]                   dac_pat_data_1,
    input  logic [CHANNEL_WIDTH-1:0]                   dac_pat_data_2,
    input  logic [CHANNEL_WIDTH*DATA_PATH_WIDTH-1:0]   dac_dma_data,
    input  logic                                       dac_dma_valid,
    output logic                                       dac_dma_ready,
    input  logic                                       dac_unf_clr,
    output logic [CHANNEL_WIDTH*DATA_PATH_WIDTH-1:0]   dac_data,
    output logic                                       dac_unf,
    output logic [15:0]                                dac_unf_count
);

    localparam int DW = CHANNEL_WIDTH * DATA_PATH_WIDTH;
    localparam logic [6:0] PN7_SEED = 7'h7F;

    logic [3:0]               sel_d;
    logic                     enable_d;
    logic                     mode_entry;
    logic [6:0]               pn7_state;
    logic [6:0]               pn7_next;
    logic [DW-1:0]            pn7_word;
    logic [CHANNEL_WIDTH-1:0] ramp_r;
    logic [CHANNEL_WIDTH-1:0] ramp_base;
    logic [CHANNEL_WIDTH-1:0] ramp_next;
    logic [DW-1:0]            ramp_word;
    logic [DW-1:0]            pat_word;
    logic [DW-1:0]            data_nxt;
    logic                     unf_nxt;
    logic [15:0]              cnt_nxt;

    assign dac_dma_ready = dac_enable && (dac_data_sel == 4'd0);

    // A select change or enable rising restarts the generators, so the first word of
    // a PN mode is always the seed word and a ramp always starts at 0.
    assign mode_entry = (dac_data_sel != sel_d) || (dac_enable && !enable_d);

    // PN7: run all DW LFSR steps in one cycle; the first bit lands in the MSB of sample 0.
    always_comb begin
        pn7_word = '0;
        pn7_next = mode_entry ? PN7_SEED : pn7_state;
        for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
            for (int b = CHANNEL_WIDTH - 1; b >= 0; b--) begin
                pn7_word[s*CHANNEL_WIDTH + b] = pn7_next[6] ^ pn7_next[5];
                pn7_next = {pn7_next[5:0], pn7_next[6] ^ pn7_next[5]};
            end
        end
    end

`ifdef AXI_DAC_JESD204_PN15_EN
    localparam logic [14:0] PN15_SEED = 15'h7FFF;

    logic [14:0]   pn15_state;
    logic [14:0]   pn15_next;
    logic [DW-1:0] pn15_word;

    always_comb begin
        pn15_word = '0;
        pn15_next = mode_entry ? PN15_SEED : pn15_state;
        for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
            for (int b = CHANNEL_WIDTH - 1; b >= 0; b--) begin
                pn15_word[s*CHANNEL_WIDTH + b] = pn15_next[14] ^ pn15_next[13];
                pn15_next = {pn15_next[13:0], pn15_next[14] ^ pn15_next[13]};
            end
        end
    end

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            pn15_state <= PN15_SEED;
        end else begin
            pn15_state <= (dac_enable && dac_data_sel == 4'd3) ? pn15_next : PN15_SEED;
        end
    end
`endif

    // Ramp and pattern words: sample n occupies [n*CHANNEL_WIDTH +: CHANNEL_WIDTH].
    always_comb begin
        ramp_base = mode_entry ? '0 : ramp_r;
        ramp_next = ramp_base + CHANNEL_WIDTH'(DATA_PATH_WIDTH);
        ramp_word = '0;
        pat_word  = '0;
        for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
            ramp_word[s*CHANNEL_WIDTH +: CHANNEL_WIDTH] = ramp_base + CHANNEL_WIDTH'(s);
            pat_word[s*CHANNEL_WIDTH +: CHANNEL_WIDTH]  = (s % 2 == 0) ? dac_pat_data_1 : dac_pat_data_2;
        end
    end

    always_comb begin
        data_nxt = '0;
        unf_nxt  = 1'b0;
        cnt_nxt  = dac_unf_count;
        if (dac_enable) begin
            case (dac_data_sel)
                4'd0: begin
                    if (dac_dma_valid) begin
                        data_nxt = dac_dma_data;
                    end else begin
                        unf_nxt = 1'b1;
                        if (dac_unf_count != 16'hFFFF) begin
                            cnt_nxt = dac_unf_count + 16'd1;
                        end
                    end
                end
                4'd1: data_nxt = pat_word;
                4'd2: data_nxt = pn7_word;
`ifdef AXI_DAC_JESD204_PN15_EN
                4'd3: data_nxt = pn15_word;
`endif
                4'd4: data_nxt = ramp_word;
                default: data_nxt = '0;
            endcase
        end
        if (dac_unf_clr) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            sel_d         <= '0;
            enable_d      <= 1'b0;
            pn7_state     <= PN7_SEED;
            ramp_r        <= '0;
            dac_data      <= '0;
            dac_unf       <= 1'b0;
            dac_unf_count <= '0;
        end else begin
            sel_d         <= dac_data_sel;
            enable_d      <= dac_enable;
            // Unselected generators sit at their reset state.
            pn7_state     <= (dac_enable && dac_data_sel == 4'd2) ? pn7_next : PN7_SEED;
            ramp_r        <= (dac_enable && dac_data_sel == 4'd4) ? ramp_next : '0;
            dac_data      <= data_nxt;
            dac_unf       <= unf_nxt;
            dac_unf_count <= cnt_nxt;
        end
    end

endmodule
